// File: rtl/id_exe_elastic_pipereg.sv
// Elastic ID->EXE pipeline register: STAGES skid-buffered stages, flush, stall.
// Ports: clk/rst_n, up (i_valid/o_ready/i_ctrl/i_data), down (o_valid/i_ready/o_ctrl/o_data), i_flush, perf counters with IDEXE_PIPEREG_PERF_EN.
module id_exe_elastic_pipereg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush
`ifdef IDEXE_PIPEREG_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
`endif
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("id_exe_elastic_pipereg: STAGES must be 1..4");
  end

  logic [STAGES-1:0] m_v;
  logic [STAGES-1:0] s_v;
  logic [CTRL_W-1:0] m_c [STAGES];
  logic [DATA_W-1:0] m_d [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic              in_v;
    logic [CTRL_W-1:0] in_c;
    logic [DATA_W-1:0] in_d;
    logic              dn_rdy;
    logic              acc;
    logic              drain;

    logic              mv;
    logic              sv;
    logic [CTRL_W-1:0] mc;
    logic [CTRL_W-1:0] sc;
    logic [DATA_W-1:0] md;
    logic [DATA_W-1:0] sd;

    if (s == 0) begin : g_in_port
      assign in_v = i_valid;
      assign in_c = i_ctrl;
      assign in_d = i_data;
    end else begin : g_in_prev
      assign in_v = m_v[s-1];
      assign in_c = m_c[s-1];
      assign in_d = m_d[s-1];
    end

    if (s == STAGES - 1) begin : g_dn_port
      assign dn_rdy = i_ready;
    end else begin : g_dn_next
      assign dn_rdy = ~s_v[s+1];
    end

    // ready toward upstream is the registered skid state only
    assign acc   = in_v & ~sv;
    assign drain = mv & dn_rdy;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
        mv <= 1'b0;
        sv <= 1'b0;
        mc <= '0;
        sc <= '0;
        md <= '0;
        sd <= '0;
      end else if (i_flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
        mc <= '0;
        sc <= '0;
      end else if (!mv || drain) begin
        if (sv) begin
          mv <= 1'b1;
          mc <= sc;
          md <= sd;
          sv <= 1'b0;
          sc <= '0;
        end else if (acc) begin
          mv <= 1'b1;
          mc <= in_c;
          md <= in_d;
        end else begin
          mv <= 1'b0;
          mc <= '0;
        end
      end else if (acc) begin
        // main is held: park the incoming entry, ready drops next cycle
        sv <= 1'b1;
        sc <= in_c;
        sd <= in_d;
      end
    end

    assign m_v[s] = mv;
    assign s_v[s] = sv;
    assign m_c[s] = mc;
    assign m_d[s] = md;
  end

  assign o_ready = ~s_v[0];
  assign o_valid = m_v[STAGES-1];
  assign o_ctrl  = m_c[STAGES-1];
  assign o_data  = m_d[STAGES-1];

`ifdef IDEXE_PIPEREG_PERF_EN
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (o_valid && !i_ready && !(&o_stall_cnt))
        o_stall_cnt <= o_stall_cnt + 1'b1;
      if (!o_valid && !(&o_bubble_cnt))
        o_bubble_cnt <= o_bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_elastic_pipereg.sv
// Scoreboard bench for id_exe_elastic_pipereg (STAGES=2 main, STAGES=1 side).
// Driver pushes accepted entries into a queue; a negedge monitor pops on transfer.
module tb_id_exe_elastic_pipereg;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   c;
  } ent_t;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         i_ready;
  logic         i_flush;
  logic [7:0]   i_ctrl;
  logic [127:0] i_data;
  logic         o_ready;
  logic         o_valid;
  logic [7:0]   o_ctrl;
  logic [127:0] o_data;
  logic         u1_ready;
  logic         u1_valid;
  logic [7:0]   u1_ctrl;
  logic [127:0] u1_data;
`ifdef IDEXE_PIPEREG_PERF_EN
  logic [3:0]   stall_cnt;
  logic [3:0]   bubble_cnt;
  logic [3:0]   u1_stall;
  logic [3:0]   u1_bubble;
`endif

  int   errors = 0;
  int   checks = 0;
  bit   run = 0;
  ent_t q[$];

  id_exe_elastic_pipereg #(
    .DATA_W(128), .CTRL_W(8), .STAGES(2), .CNT_W(4)
  ) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_ctrl(i_ctrl), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_ctrl(o_ctrl), .o_data(o_data),
    .i_flush(i_flush)
`ifdef IDEXE_PIPEREG_PERF_EN
    , .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
`endif
  );

  id_exe_elastic_pipereg #(
    .DATA_W(128), .CTRL_W(8), .STAGES(1), .CNT_W(4)
  ) u1 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(u1_ready),
    .i_ctrl(i_ctrl), .i_data(i_data),
    .o_valid(u1_valid), .i_ready(i_ready),
    .o_ctrl(u1_ctrl), .o_data(u1_data),
    .i_flush(i_flush)
`ifdef IDEXE_PIPEREG_PERF_EN
    , .o_stall_cnt(u1_stall), .o_bubble_cnt(u1_bubble)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic push(input logic [127:0] d, input logic [7:0] c);
    bit done = 0;
    i_valid = 1;
    i_data  = d;
    i_ctrl  = c;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (o_ready && !i_flush) begin
        q.push_back('{d: d, c: c});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (run && rst_n) begin
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", o_data, 0);
        end else begin
          ent_t e;
          e = q.pop_front();
          chk("out_data", o_data, e.d);
          chk("out_ctrl", {120'd0, o_ctrl}, {120'd0, e.c});
        end
      end else if (!o_valid) begin
        chk("idle_ctrl", {120'd0, o_ctrl}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    logic [127:0] held;
    rst_n   = 0;
    i_valid = 0;
    i_ready = 1;
    i_flush = 0;
    i_ctrl  = 0;
    i_data  = 0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rel_valid", o_valid, 0);
    chk("rel_ctrl", o_ctrl, 0);
    chk("rel_data", o_data, 0);
    chk("rel_ready", o_ready, 1);
    chk("s1_valid", u1_valid, 0);
    chk("s1_ctrl", u1_ctrl, 0);
    chk("s1_data", u1_data, 0);
    chk("s1_ready", u1_ready, 1);
`ifdef IDEXE_PIPEREG_PERF_EN
    chk("perf_rst", stall_cnt, 0);
`endif
    run = 1;

    // streaming, full throughput
    push(1, 8'h11);
    chk("lat_cyc1", o_valid, 0);
    chk("s1_lat_v", u1_valid, 1);
    chk("s1_lat_d", u1_data, 1);
    t0 = $time;
    push(2, 8'h12);
    chk("lat_cyc2_v", o_valid, 1);
    chk("lat_cyc2_d", o_data, 1);
    for (int i = 3; i <= 8; i++) push(i, 8'h10 + 8'(i));
    chk("thruput", $time - t0, 70);
    drain();

    // back-pressure fills all four slots
    i_ready = 0;
    for (int i = 1; i <= 4; i++) push(100 + i, 8'h20 + 8'(i));
    chk("full_ready", o_ready, 0);
    chk("full_head", o_data, 101);
    held = o_data;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid", o_valid, 1);
    chk("stall_data", o_data, held);
    chk("stall_ctrl", o_ctrl, 8'h21);
    i_ready = 1;
    fork
      push(105, 8'h25);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("b2b_valid", o_valid, 1);
      end
    join
    drain();

    // flush with a new entry offered
    i_ready = 0;
    push(201, 8'hFF);
    push(202, 8'hFF);
    i_valid = 1;
    i_data  = 203;
    i_ctrl  = 8'hFF;
    i_flush = 1;
    @(posedge clk);
    #1;
    i_flush = 0;
    i_valid = 0;
    q.delete();
    chk("flush_valid", o_valid, 0);
    chk("flush_ctrl", o_ctrl, 0);
    chk("flush_ready", o_ready, 1);
    chk("flush_data_kept", o_data, 201);
    i_ready = 1;
    push(204, 8'h33);
    drain();

    // async reset between edges
    i_ready = 0;
    push(301, 8'h0F);
    push(302, 8'h0F);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ctrl", o_ctrl, 0);
    chk("arst_data", o_data, 0);
    chk("arst_ready", o_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

`ifdef IDEXE_PIPEREG_PERF_EN
    chk("perf_clr", stall_cnt, 0);
    push(401, 8'h44);
    repeat (20) @(posedge clk);
    #1;
    chk("perf_sat", stall_cnt, 15);
    i_flush = 1;
    @(posedge clk);
    #1;
    i_flush = 0;
    q.delete();
    chk("perf_flush", stall_cnt, 15);
`endif

    i_ready = 1;
    push(501, 8'h55);
    drain();
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
